// File: rtl/data_mem_responder.sv
// Purpose: single-port data memory slave for a pipeline MEM stage, byte/half/word access with alignment and range checks.
// Latency: response (Ack, ReadData, AccessError) arrives LATENCY edges after acceptance, counted from the accepting edge inclusive.
// Backpressure: Ready is high only when idle; requests presented while busy are ignored, so spacing is LATENCY+1 cycles.
module data_mem_responder #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req,
   input  logic        ReqWrite,
   input  logic [1:0]  Size,
   input  logic        SignedLoad,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic        Ready,
   output logic        Ack,
   output logic [31:0] ReadData,
   output logic        AccessError
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;
   logic            signed_q, signed_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   // Storage is deliberately not reset.
   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept;
   logic            in_err;
   logic            go_resp;
   logic            t_write;
   logic [1:0]      t_size;
   logic            t_signed;
   logic [AW+1:0]   t_addr;
   logic [31:0]     t_wdata;
   logic            t_err;
   logic [AW-1:0]   word_idx;
   logic [31:0]     rd_word;
   logic [31:0]     rd_shift;
   logic [31:0]     load_val;
   logic [3:0]      wmask;
   logic [31:0]     wdata_rep;
   logic            mem_we;

   // Request decode: error classification and the transaction view used on the edge entering RESP.
   // With LATENCY == 1 the accepting edge is also the response edge, so live inputs are used then.
   always_comb begin
      accept = (state_q == S_IDLE) && Req;
      in_err = ({1'b0, Address} >= ADDR_LIMIT);
      case (Size)
         2'b00:   in_err = in_err | (Address[1:0] != 2'b00);
         2'b01:   in_err = in_err | Address[0];
         2'b10:   in_err = in_err;
         default: in_err = 1'b1;
      endcase
      t_write  = accept ? ReqWrite            : write_q;
      t_size   = accept ? Size                : size_q;
      t_signed = accept ? SignedLoad          : signed_q;
      t_addr   = accept ? Address[AW+1:0]     : addr_q;
      t_wdata  = accept ? WriteData           : wdata_q;
      t_err    = accept ? in_err              : err_q;
      go_resp  = (accept && (LATENCY == 1)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
   end

   // Datapath: lane steering for stores, extraction and extension for loads.
   always_comb begin
      word_idx = t_addr[AW+1:2];
      rd_word  = mem[word_idx];
      rd_shift = rd_word >> {t_addr[1:0], 3'b000};
      case (t_size)
         2'b01:   load_val = {{16{t_signed & rd_shift[15]}}, rd_shift[15:0]};
         2'b10:   load_val = {{24{t_signed & rd_shift[7]}}, rd_shift[7:0]};
         default: load_val = rd_word;
      endcase
      case (t_size)
         2'b01: begin
            wmask     = t_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{t_wdata[15:0]}};
         end
         2'b10: begin
            wmask     = 4'b0001 << t_addr[1:0];
            wdata_rep = {4{t_wdata[7:0]}};
         end
         default: begin
            wmask     = 4'b1111;
            wdata_rep = t_wdata;
         end
      endcase
      // Rst gating keeps a LATENCY==1 request from writing while held in reset.
      mem_we  = go_resp && t_write && !t_err && !Rst;
      rdata_d = rdata_q;
      if (go_resp && !t_write && !t_err) begin
         rdata_d = load_val;
      end
   end

   // FSM next state, wait counter and request capture; captured fields only change on acceptance.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (Req) begin
               write_d  = ReqWrite;
               size_d   = Size;
               signed_d = SignedLoad;
               addr_d   = Address[AW+1:0];
               wdata_d  = WriteData;
               err_d    = in_err;
               cnt_d    = 4'(LATENCY - 1);
               state_d  = (LATENCY > 1) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and result registers; reset abandons any in-flight transaction.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Byte-lane store into storage on the edge entering RESP.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we && wmask[i]) begin
            mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   assign Ready       = (state_q == S_IDLE);
   assign Ack         = (state_q == S_RESP);
   assign AccessError = (state_q == S_RESP) && err_q;
   assign ReadData    = rdata_q;

endmodule
